// File: rtl/accumulator.sv
// Integrate-and-dump accumulator: sums ACC_LEN unsigned samples and emits one wide sum per frame.
// Optional feature: define ACCUMULATOR_SATURATE_EN to clamp instead of wrap on overflow.
module accumulator #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_LEN    = 4,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic                  sync_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [ACC_WIDTH-1:0]  data_o,
    output logic                  valid_o,
    output logic                  overflow_o
);

    localparam logic [0:0]  IDLE       = 1'b0;
    localparam logic [0:0]  ACCUM      = 1'b1;
    localparam logic [15:0] LAST_COUNT = 16'(ACC_LEN - 1);

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [15:0]          count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic [0:0]           state_q, state_d;
    logic [ACC_WIDTH-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 overflow_q, overflow_d;

    logic                 fresh;
    logic [ACC_WIDTH-1:0] acc_base;
    logic [15:0]          count_base;
    logic                 ovf_base;
    logic [ACC_WIDTH:0]   sum;
    logic                 ovf_next;
    logic [ACC_WIDTH-1:0] acc_next;

    // A sync (or an idle frame) starts from zero, so this cycle's sample becomes sample 0.
    always_comb begin
        fresh      = sync_i || (state_q == IDLE);
        acc_base   = fresh ? '0 : acc_q;
        count_base = fresh ? 16'd0 : count_q;
        ovf_base   = fresh ? 1'b0 : ovf_q;
        sum        = {1'b0, acc_base} + (ACC_WIDTH + 1)'(data_i);
        ovf_next   = ovf_base | sum[ACC_WIDTH];
`ifdef ACCUMULATOR_SATURATE_EN
        acc_next   = ovf_next ? '1 : sum[ACC_WIDTH-1:0];
`else
        acc_next   = sum[ACC_WIDTH-1:0];
`endif
    end

    always_comb begin
        acc_d      = acc_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        state_d    = state_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        overflow_d = overflow_q;
        if (en_i) begin
            if (count_base == LAST_COUNT) begin
                data_d     = acc_next;
                overflow_d = ovf_next;
                valid_d    = 1'b1;
                acc_d      = '0;
                count_d    = 16'd0;
                ovf_d      = 1'b0;
                state_d    = IDLE;
            end else begin
                acc_d      = acc_next;
                count_d    = count_base + 16'd1;
                ovf_d      = ovf_next;
                state_d    = ACCUM;
            end
        end else if (sync_i) begin
            acc_d   = '0;
            count_d = 16'd0;
            ovf_d   = 1'b0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            count_q    <= 16'd0;
            ovf_q      <= 1'b0;
            state_q    <= IDLE;
            data_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_accumulator.sv
// Directed testbench for accumulator: three instances share stimulus (24-bit/len 4, 16-bit/len 4, len 1).
// Expected overflow value for the narrow instance depends on ACCUMULATOR_SATURATE_EN.
module tb_accumulator;

    logic        clk;
    logic        rst;
    logic        en_i;
    logic        sync_i;
    logic [15:0] data_i;

    logic [23:0] a_data;
    logic        a_valid, a_ovf;
    logic [15:0] b_data;
    logic        b_valid, b_ovf;
    logic [23:0] c_data;
    logic        c_valid, c_ovf;

    int checks = 0;
    int errors = 0;

    accumulator #(.DATA_WIDTH(16), .ACC_LEN(4), .ACC_WIDTH(24)) u_a (
        .clk(clk), .rst(rst), .en_i(en_i), .sync_i(sync_i), .data_i(data_i),
        .data_o(a_data), .valid_o(a_valid), .overflow_o(a_ovf)
    );

    accumulator #(.DATA_WIDTH(16), .ACC_LEN(4), .ACC_WIDTH(16)) u_b (
        .clk(clk), .rst(rst), .en_i(en_i), .sync_i(sync_i), .data_i(data_i),
        .data_o(b_data), .valid_o(b_valid), .overflow_o(b_ovf)
    );

    accumulator #(.DATA_WIDTH(16), .ACC_LEN(1), .ACC_WIDTH(24)) u_c (
        .clk(clk), .rst(rst), .en_i(en_i), .sync_i(sync_i), .data_i(data_i),
        .data_o(c_data), .valid_o(c_valid), .overflow_o(c_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs; outputs are observed 1 time unit after the capturing edge.
    task automatic applyStimulus(input logic en, input logic sync, input logic [15:0] data);
        en_i   = en;
        sync_i = sync;
        data_i = data;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'd0);
        rst = 1'b0;
    endtask

    logic [15:0] frame1 [4];
    logic [31:0] exp_b;

    initial begin
        rst    = 1'b1;
        en_i   = 1'b0;
        sync_i = 1'b0;
        data_i = 16'd0;
        frame1[0] = 16'd6;
        frame1[1] = 16'd18;
        frame1[2] = 16'd81;
        frame1[3] = 16'hFE01;
        applyStimulus(1'b0, 1'b0, 16'd0);
        applyStimulus(1'b0, 1'b0, 16'd0);
        checkOutput("reset data", 32'(a_data), 32'h0);
        checkOutput("reset valid", 32'(a_valid), 32'h0);
        checkOutput("reset ovf", 32'(a_ovf), 32'h0);
        rst = 1'b0;

        $display("[TB] test 1: four back-to-back samples");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, frame1[i]);
            checkOutput($sformatf("t1 valid s%0d", i), 32'(a_valid), (i == 3) ? 32'h1 : 32'h0);
        end
        checkOutput("t1 data", 32'(a_data), 32'd6 + 32'd18 + 32'd81 + 32'hFE01);
        checkOutput("t1 ovf", 32'(a_ovf), 32'h0);
        applyStimulus(1'b0, 1'b0, 16'd0);
        checkOutput("t1 valid drop", 32'(a_valid), 32'h0);
        checkOutput("t1 data hold", 32'(a_data), 32'hFE6A);

        $display("[TB] test 2: same samples with gaps");
        doReset();
        checkOutput("t2 reset data", 32'(a_data), 32'h0);
        applyStimulus(1'b1, 1'b0, frame1[0]);
        applyStimulus(1'b0, 1'b0, 16'hAAAA);
        checkOutput("t2 gap1 valid", 32'(a_valid), 32'h0);
        applyStimulus(1'b1, 1'b0, frame1[1]);
        for (int g = 0; g < 3; g++) begin
            applyStimulus(1'b0, 1'b0, 16'h5555);
            checkOutput($sformatf("t2 gap3 valid %0d", g), 32'(a_valid), 32'h0);
        end
        applyStimulus(1'b1, 1'b0, frame1[2]);
        checkOutput("t2 valid s2", 32'(a_valid), 32'h0);
        applyStimulus(1'b1, 1'b0, frame1[3]);
        checkOutput("t2 valid", 32'(a_valid), 32'h1);
        checkOutput("t2 data", 32'(a_data), 32'hFE6A);

        $display("[TB] test 3: sync with enable discards partial sum");
        applyStimulus(1'b1, 1'b0, 16'd100);
        applyStimulus(1'b1, 1'b0, 16'd200);
        applyStimulus(1'b1, 1'b1, 16'd5);
        checkOutput("t3 valid after sync", 32'(a_valid), 32'h0);
        applyStimulus(1'b1, 1'b0, 16'd1);
        applyStimulus(1'b1, 1'b0, 16'd1);
        checkOutput("t3 valid early", 32'(a_valid), 32'h0);
        applyStimulus(1'b1, 1'b0, 16'd1);
        checkOutput("t3 valid", 32'(a_valid), 32'h1);
        checkOutput("t3 data", 32'(a_data), 32'd8);

        $display("[TB] test 3b: sync without enable clears frame");
        applyStimulus(1'b1, 1'b0, 16'd50);
        applyStimulus(1'b0, 1'b1, 16'd0);
        checkOutput("t3b valid", 32'(a_valid), 32'h0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 16'd1);
        checkOutput("t3b data", 32'(a_data), 32'd4);

        $display("[TB] test 4: overflow on narrow accumulator");
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 16'hFE01);
`ifdef ACCUMULATOR_SATURATE_EN
        exp_b = 32'hFFFF;
`else
        exp_b = 32'hF804;
`endif
        checkOutput("t4 narrow valid", 32'(b_valid), 32'h1);
        checkOutput("t4 narrow data", 32'(b_data), exp_b);
        checkOutput("t4 narrow ovf", 32'(b_ovf), 32'h1);
        checkOutput("t4 wide data", 32'(a_data), 32'h3F804);
        checkOutput("t4 wide ovf", 32'(a_ovf), 32'h0);

        $display("[TB] test 5: reset mid-frame");
        applyStimulus(1'b1, 1'b0, 16'd7);
        applyStimulus(1'b1, 1'b0, 16'd9);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 16'd3);
        checkOutput("t5 rst data", 32'(a_data), 32'h0);
        checkOutput("t5 rst valid", 32'(a_valid), 32'h0);
        checkOutput("t5 rst narrow ovf", 32'(b_ovf), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 16'd1);
        checkOutput("t5 valid", 32'(a_valid), 32'h1);
        checkOutput("t5 data", 32'(a_data), 32'd4);
        checkOutput("t5 ovf", 32'(a_ovf), 32'h0);

        $display("[TB] test 5b: back-to-back frames");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 16'(i + 1));
        checkOutput("t5b frame1", 32'(a_data), 32'd10);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 16'd10);
            checkOutput($sformatf("t5b no valid %0d", i), 32'(a_valid), 32'h0);
        end
        applyStimulus(1'b1, 1'b0, 16'd10);
        checkOutput("t5b frame2 valid", 32'(a_valid), 32'h1);
        checkOutput("t5b frame2", 32'(a_data), 32'd40);

        $display("[TB] test 6: ACC_LEN of one");
        doReset();
        applyStimulus(1'b1, 1'b0, 16'd3);
        checkOutput("t6 valid0", 32'(c_valid), 32'h1);
        checkOutput("t6 data0", 32'(c_data), 32'd3);
        applyStimulus(1'b1, 1'b0, 16'd9);
        checkOutput("t6 valid1", 32'(c_valid), 32'h1);
        checkOutput("t6 data1", 32'(c_data), 32'd9);
        applyStimulus(1'b1, 1'b0, 16'hFFFF);
        checkOutput("t6 valid2", 32'(c_valid), 32'h1);
        checkOutput("t6 data2", 32'(c_data), 32'hFFFF);
        checkOutput("t6 ovf", 32'(c_ovf), 32'h0);
        applyStimulus(1'b0, 1'b0, 16'd0);
        checkOutput("t6 valid idle", 32'(c_valid), 32'h0);
        checkOutput("t6 data hold", 32'(c_data), 32'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
